mmio_bus_fabric: RTL and testbench

//  Parametrised single-master MMIO fabric between the NJU_MIPS data port and NUM_SLV memory/device slaves.

---
 rtl/mmio_bus_fabric_pkg.sv | 21 ++
 rtl/mmio_addr_decode.sv | 33 +++
 rtl/mmio_bus_fabric.sv | 118 +++++++++++
 tb/tb_mmio_bus_fabric.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mmio_bus_fabric_pkg.sv
// mmio_bus_fabric_pkg: default SOPC memory map and fabric FSM encoding shared by the MMIO fabric files.
package mmio_bus_fabric_pkg;
   localparam int unsigned MMIO_MAX_SLV = 8;
   localparam int unsigned MMIO_IDX_W   = 3;
   localparam int unsigned MMIO_LAT_W   = 4;
   localparam logic [31:0] MMIO_ROM_BASE  = 32'h0000_0000;
   localparam logic [31:0] MMIO_ROM_SIZE  = 32'h0001_0000;
   localparam logic [31:0] MMIO_GRAM_BASE = 32'h0010_0000;
   localparam logic [31:0] MMIO_GRAM_SIZE = 32'h0000_1000;
   localparam logic [31:0] MMIO_RAM_BASE  = 32'h0020_0000;
   localparam logic [31:0] MMIO_RAM_SIZE  = 32'h0001_0000;
   localparam logic [31:0] MMIO_IO_BASE   = 32'h1000_0000;
   localparam logic [31:0] MMIO_IO_SIZE   = 32'h0000_0100;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESP,
      ST_ERR
   } mmio_state_e;
endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: maps a byte address onto the lowest-indexed matching base/size window.
module mmio_addr_decode
   import mmio_bus_fabric_pkg::*;
#(
   parameter int unsigned             NUM_SLV  = 4,
   parameter logic [32*NUM_SLV-1:0]   SLV_BASE = {MMIO_IO_BASE, MMIO_RAM_BASE, MMIO_GRAM_BASE, MMIO_ROM_BASE},
   parameter logic [32*NUM_SLV-1:0]   SLV_SIZE = {MMIO_IO_SIZE, MMIO_RAM_SIZE, MMIO_GRAM_SIZE, MMIO_ROM_SIZE}
) (
   input  logic [31:0]            addr_i,
   output logic                   hit_vld_o,
   output logic [MMIO_IDX_W-1:0]  hit_idx_o,
   output logic [31:0]            offset_o
);
   logic [NUM_SLV-1:0] hit;
   for (genvar g = 0; g < NUM_SLV; g++) begin : g_win
      logic [32:0] diff;
      // Bit 32 of the 33-bit difference is the borrow, i.e. addr below base.
      assign diff   = {1'b0, addr_i} - {1'b0, SLV_BASE[32*g+:32]};
      assign hit[g] = !diff[32] && (diff < {1'b0, SLV_SIZE[32*g+:32]});
   end
   always_comb begin
      hit_vld_o = 1'b0;
      hit_idx_o = '0;
      offset_o  = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_vld_o = 1'b1;
            hit_idx_o = MMIO_IDX_W'(i);
            offset_o  = addr_i - SLV_BASE[32*i+:32];
         end
      end
   end
endmodule

// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: single-master MMIO fabric with window decode, per-slave fixed read latency and error responses.
module mmio_bus_fabric
   import mmio_bus_fabric_pkg::*;
#(
   parameter int unsigned                     NUM_SLV  = 4,
   parameter logic [32*NUM_SLV-1:0]           SLV_BASE = {MMIO_IO_BASE, MMIO_RAM_BASE, MMIO_GRAM_BASE, MMIO_ROM_BASE},
   parameter logic [32*NUM_SLV-1:0]           SLV_SIZE = {MMIO_IO_SIZE, MMIO_RAM_SIZE, MMIO_GRAM_SIZE, MMIO_ROM_SIZE},
   parameter logic [MMIO_LAT_W*NUM_SLV-1:0]   SLV_LAT  = {4'd3, 4'd2, 4'd1, 4'd1},
   parameter logic [NUM_SLV-1:0]              SLV_RO   = 4'b0001,
   parameter logic [31:0]                     ERR_DATA = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    m_ce_i,
   input  logic                    m_we_i,
   input  logic [31:0]             m_addr_i,
   input  logic [3:0]              m_sel_i,
   input  logic [31:0]             m_wdata_i,
   output logic [31:0]             m_rdata_o,
   output logic                    m_ready_o,
   output logic                    m_err_o,
   output logic [NUM_SLV-1:0]      s_ce_o,
   output logic                    s_we_o,
   output logic [31:0]             s_addr_o,
   output logic [3:0]              s_sel_o,
   output logic [31:0]             s_wdata_o,
   input  logic [32*NUM_SLV-1:0]   s_rdata_i
);
   mmio_state_e            state_q;
   logic [MMIO_IDX_W-1:0]  idx_q;
   logic [MMIO_LAT_W-1:0]  cnt_q;
   logic                   hit_vld;
   logic [MMIO_IDX_W-1:0]  hit_idx;
   logic [31:0]            offset;
   logic [MMIO_LAT_W-1:0]  lat [MMIO_MAX_SLV];
   logic [31:0]            rd  [MMIO_MAX_SLV];
   logic [MMIO_MAX_SLV-1:0] ro;

   mmio_addr_decode #(
      .NUM_SLV  (NUM_SLV),
      .SLV_BASE (SLV_BASE),
      .SLV_SIZE (SLV_SIZE)
   ) u_dec (
      .addr_i    (m_addr_i),
      .hit_vld_o (hit_vld),
      .hit_idx_o (hit_idx),
      .offset_o  (offset)
   );

   // Pad per-slave tables to the full index range so the 3-bit index never selects out of range.
   for (genvar g = 0; g < MMIO_MAX_SLV; g++) begin : g_slv
      if (g < NUM_SLV) begin : g_on
         assign lat[g] = SLV_LAT[MMIO_LAT_W*g+:MMIO_LAT_W];
         assign rd[g]  = s_rdata_i[32*g+:32];
         assign ro[g]  = SLV_RO[g];
      end else begin : g_off
         assign lat[g] = '0;
         assign rd[g]  = '0;
         assign ro[g]  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         m_rdata_o <= '0;
         m_ready_o <= 1'b0;
         m_err_o   <= 1'b0;
         s_ce_o    <= '0;
         s_we_o    <= 1'b0;
         s_addr_o  <= '0;
         s_sel_o   <= '0;
         s_wdata_o <= '0;
      end else begin
         s_ce_o    <= '0;
         s_we_o    <= 1'b0;
         m_ready_o <= 1'b0;
         m_err_o   <= 1'b0;
         unique case (state_q)
            ST_IDLE: if (m_ce_i) begin
               if (!hit_vld || (m_we_i && ro[hit_idx])) begin
                  state_q   <= ST_ERR;
                  m_ready_o <= 1'b1;
                  m_err_o   <= 1'b1;
                  m_rdata_o <= ERR_DATA;
               end else begin
                  state_q   <= ST_ACCESS;
                  idx_q     <= hit_idx;
                  cnt_q     <= lat[hit_idx] - 1'b1;
                  s_ce_o    <= NUM_SLV'(1) << hit_idx;
                  s_we_o    <= m_we_i;
                  s_addr_o  <= offset;
                  s_sel_o   <= m_sel_i;
                  s_wdata_o <= m_wdata_i;
               end
            end
            ST_ACCESS: begin
               state_q <= (cnt_q == '0) ? ST_RESP : ST_WAIT;
               if (cnt_q == '0) begin
                  m_rdata_o <= rd[idx_q];
                  m_ready_o <= 1'b1;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == MMIO_LAT_W'(1)) begin
                  state_q   <= ST_RESP;
                  m_rdata_o <= rd[idx_q];
                  m_ready_o <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_bus_fabric.sv
// tb_mmio_bus_fabric: directed and randomized accesses checked against a window-table model of the fabric.
module tb_mmio_bus_fabric;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         m_ce = 1'b0, m_we = 1'b0;
   logic [31:0]  m_addr = '0, m_wdata = '0;
   logic [3:0]   m_sel = '0;
   logic [31:0]  m_rdata;
   logic         m_ready, m_err;
   logic [3:0]   s_ce;
   logic         s_we;
   logic [31:0]  s_addr, s_wdata;
   logic [3:0]   s_sel;
   logic [127:0] s_rdata;
   logic [31:0]  sd [4];
   int           n_cmp = 0;
   int           n_err = 0;

   // Memory map as documented for the SOPC: ROM, GRAM, RAM, IO.
   logic [31:0] base_a [4] = '{32'h0000_0000, 32'h0010_0000, 32'h0020_0000, 32'h1000_0000};
   logic [31:0] size_a [4] = '{32'h0001_0000, 32'h0000_1000, 32'h0001_0000, 32'h0000_0100};
   int          lat_a  [4] = '{1, 1, 2, 3};
   bit          ro_a   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

   assign s_rdata = {sd[3], sd[2], sd[1], sd[0]};

   always #5 clk = ~clk;

   mmio_bus_fabric dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m_ce_i    (m_ce),
      .m_we_i    (m_we),
      .m_addr_i  (m_addr),
      .m_sel_i   (m_sel),
      .m_wdata_i (m_wdata),
      .m_rdata_o (m_rdata),
      .m_ready_o (m_ready),
      .m_err_o   (m_err),
      .s_ce_o    (s_ce),
      .s_we_o    (s_we),
      .s_addr_o  (s_addr),
      .s_sel_o   (s_sel),
      .s_wdata_o (s_wdata),
      .s_rdata_i (s_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int ref_idx(input logic [31:0] a);
      for (int i = 0; i < 4; i++)
         if (64'(a) >= 64'(base_a[i]) && 64'(a) < 64'(base_a[i]) + 64'(size_a[i])) return i;
      return -1;
   endfunction

   task automatic acc(input logic [31:0] a, input logic we, input logic [3:0] sel,
                      input logic [31:0] wd, input bit hold, input int extra);
      int idx, exp_n, n, ce_n;
      bit err;
      idx   = ref_idx(a);
      err   = (idx < 0) ? 1'b1 : (we && ro_a[idx]);
      exp_n = (err ? 1 : lat_a[idx] + 1) + extra;
      m_addr = a; m_we = we; m_sel = sel; m_wdata = wd; m_ce = 1'b1;
      n = 0; ce_n = 0;
      do begin
         @(negedge clk);
         n++;
         if (s_ce !== 4'b0) begin
            ce_n++;
            if (err) chk("s_ce_on_err", 32'(s_ce), 32'h0);
            else begin
               chk("s_ce", 32'(s_ce), 32'(1) << idx);
               chk("s_addr", s_addr, a - base_a[idx]);
               chk("s_we", 32'(s_we), 32'(we));
               chk("s_sel", 32'(s_sel), 32'(sel));
               chk("s_wdata", s_wdata, wd);
            end
         end
      end while (m_ready !== 1'b1 && n < 40);
      chk("latency", n, exp_n);
      chk("m_err", 32'(m_err), 32'(err));
      chk("ce_cycles", ce_n, err ? 0 : 1);
      if (err) chk("err_rdata", m_rdata, 32'h0);
      else if (!we) chk("rdata", m_rdata, sd[idx]);
      if (!hold) begin
         m_ce = 1'b0;
         @(negedge clk);
         chk("ready_pulse", 32'(m_ready), 32'h0);
      end
   endtask

   initial begin
      int w, rdy_n;
      logic [31:0] a;
      for (int i = 0; i < 4; i++) sd[i] = $urandom;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'({m_ready, m_err, s_we}), 32'h0);
      chk("rst_s_ce", 32'(s_ce), 32'h0);
      chk("rst_rdata", m_rdata, 32'h0);
      chk("rst_s_addr", s_addr, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      sd[2] = 32'hCAFE_F00D;
      acc(32'h0020_0010, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'h0010_0004, 1'b1, 4'b0011, 32'h1234, 1'b0, 0);
      sd[3] = 32'h0BAD_BEEF;
      acc(32'h1000_0020, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'h0000_0100, 1'b1, 4'hF, 32'h55, 1'b0, 0);
      acc(32'h0030_0000, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'h0010_0FFF, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'h0010_1000, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'h0000_FFFF, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'h0001_0000, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'h1000_00FF, 1'b1, 4'b1000, 32'hA5A5_0000, 1'b0, 0);
      acc(32'h1000_0100, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      acc(32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      // Back-to-back with m_ce held: second request waits one idle cycle.
      for (int i = 0; i < 4; i++) sd[i] = $urandom;
      acc(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 0);
      acc(32'h1000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1);
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 4; i++) sd[i] = $urandom;
         w = int'($urandom_range(0, 4));
         a = (w < 4) ? base_a[w] + 32'($urandom_range(0, int'(size_a[w]) - 1)) : $urandom;
         acc(a, 1'($urandom), 4'($urandom), $urandom, 1'b0, 0);
      end
      sd[3] = $urandom;
      m_addr = 32'h1000_0010; m_we = 1'b0; m_sel = 4'hF; m_wdata = 32'hDEAD; m_ce = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ctrl", 32'({m_ready, m_err, s_we}), 32'h0);
      chk("arst_s_ce", 32'(s_ce), 32'h0);
      chk("arst_rdata", m_rdata, 32'h0);
      chk("arst_s_addr", s_addr, 32'h0);
      chk("arst_s_sel", 32'(s_sel), 32'h0);
      chk("arst_s_wdata", s_wdata, 32'h0);
      m_ce = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rdy_n = 0;
      repeat (8) begin
         @(negedge clk);
         if (m_ready === 1'b1 || s_ce !== 4'b0) rdy_n++;
      end
      chk("no_resp_after_rst", rdy_n, 0);
      sd[2] = $urandom;
      acc(32'h0020_0100, 1'b0, 4'hF, 32'h0, 1'b0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
